// File: rtl/pipe_cf_scaler.sv
// Elastic multi-channel correction-factor pipe: scales each channel by i_cf, passing 0/all-ones codes through.
// Define PIPE_CF_SAT_EN to saturate overflowing channels to all-ones instead of truncating.
module pipe_cf_scaler #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 16,
    parameter int CF_W   = 2,
    parameter int STAGES = 2,
    parameter int CNT_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [CF_W-1:0]          i_cf,
    input  logic                     i_en,
    input  logic                     i_valid,
    output logic                     i_ready,
    input  logic [NUM_CH*DATA_W-1:0] i_data,
    output logic                     o_valid,
    input  logic                     o_ready,
    output logic [NUM_CH*DATA_W-1:0] o_data,
    output logic [NUM_CH-1:0]        o_ovf,
    output logic [CNT_W-1:0]         o_sample_cnt
);

    localparam int W    = NUM_CH * DATA_W;
    localparam int LAST = STAGES - 1;

    logic [STAGES-1:0] vld_r;
    logic [STAGES-1:0] adv_s;
    logic [W-1:0]      data_r [STAGES];
    logic [NUM_CH-1:0] ovf_r  [STAGES];
    logic [W-1:0]      corr_data_s;
    logic [NUM_CH-1:0] corr_ovf_s;
    logic [DATA_W:0]   ch_res_s;
    logic [CNT_W-1:0]  cnt_r;

    // Returns {ovf, result} for one channel.
    function automatic logic [DATA_W:0] correct_ch(
        input logic [DATA_W-1:0] d,
        input logic [CF_W-1:0]   cf,
        input logic              en
    );
        logic [DATA_W+CF_W-1:0] p;
        logic                   ovf;
        logic [DATA_W-1:0]      res;
        p = {{CF_W{1'b0}}, d} * {{DATA_W{1'b0}}, cf};
        if (!en || (d == {DATA_W{1'b0}}) || (d == {DATA_W{1'b1}})) begin
            ovf = 1'b0;
            res = d;
        end else begin
            ovf = |p[DATA_W+CF_W-1:DATA_W];
`ifdef PIPE_CF_SAT_EN
            res = ovf ? {DATA_W{1'b1}} : p[DATA_W-1:0];
`else
            res = p[DATA_W-1:0];
`endif
        end
        return {ovf, res};
    endfunction

    // Per-channel correction of the incoming sample.
    always_comb begin
        corr_data_s = {W{1'b0}};
        corr_ovf_s  = {NUM_CH{1'b0}};
        ch_res_s    = {(DATA_W+1){1'b0}};
        for (int k = 0; k < NUM_CH; k++) begin
            ch_res_s = correct_ch(i_data[k*DATA_W +: DATA_W], i_cf, i_en);
            corr_data_s[k*DATA_W +: DATA_W] = ch_res_s[DATA_W-1:0];
            corr_ovf_s[k] = ch_res_s[DATA_W];
        end
    end

    // Stage s may advance if o_ready is high or any stage from s to the output is empty.
    always_comb begin
        logic chain;
        chain = o_ready;
        adv_s = {STAGES{1'b0}};
        for (int s = LAST; s >= 0; s--) begin
            chain    = chain | ~vld_r[s];
            adv_s[s] = chain;
        end
    end

    assign i_ready = adv_s[0];

    // Pipeline stage registers and output handshake counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_r <= {STAGES{1'b0}};
            for (int s = 0; s < STAGES; s++) begin
                data_r[s] <= {W{1'b0}};
                ovf_r[s]  <= {NUM_CH{1'b0}};
            end
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (adv_s[0]) begin
                vld_r[0]  <= i_valid;
                data_r[0] <= corr_data_s;
                ovf_r[0]  <= corr_ovf_s;
            end
            for (int s = 1; s < STAGES; s++) begin
                if (adv_s[s]) begin
                    vld_r[s]  <= vld_r[s-1];
                    data_r[s] <= data_r[s-1];
                    ovf_r[s]  <= ovf_r[s-1];
                end
            end
            if (vld_r[LAST] && o_ready) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    assign o_valid      = vld_r[LAST];
    assign o_data       = data_r[LAST];
    assign o_ovf        = ovf_r[LAST];
    assign o_sample_cnt = cnt_r;

endmodule

// File: tb/tb_pipe_cf_scaler.sv
// Directed self-checking bench for pipe_cf_scaler; a second instance with CNT_W=4 checks counter wrap.
module tb_pipe_cf_scaler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  i_cf = 2'd0;
    logic        i_en = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready = 1'b1;
    logic [31:0] i_data = 32'h0;
    logic        i_ready, o_valid;
    logic [31:0] o_data;
    logic [1:0]  o_ovf;
    logic [31:0] o_sample_cnt;
    logic        w_ready, w_valid;
    logic [31:0] w_data;
    logic [1:0]  w_ovf;
    logic [3:0]  w_cnt;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef PIPE_CF_SAT_EN
    localparam logic [31:0] EXP_OVF_DATA = 32'h0000_FFFF;
`else
    localparam logic [31:0] EXP_OVF_DATA = 32'h0000_2000;
`endif

    pipe_cf_scaler dut (
        .clk(clk), .rst_n(rst_n), .i_cf(i_cf), .i_en(i_en), .i_valid(i_valid),
        .i_ready(i_ready), .i_data(i_data), .o_valid(o_valid), .o_ready(o_ready),
        .o_data(o_data), .o_ovf(o_ovf), .o_sample_cnt(o_sample_cnt)
    );

    pipe_cf_scaler #(.CNT_W(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .i_cf(i_cf), .i_en(i_en), .i_valid(i_valid),
        .i_ready(w_ready), .i_data(i_data), .o_valid(w_valid), .o_ready(o_ready),
        .o_data(w_data), .o_ovf(w_ovf), .o_sample_cnt(w_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] cf, input logic en, input logic [31:0] d);
        i_cf = cf;
        i_en = en;
        i_data = d;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
    endtask

    // Streams ch0 = 1..n with cf=1; o_ready low during cycles [stall_at, stall_at+stall_len).
    task automatic stream(input int n, input int stall_at, input int stall_len, input bit chk_tp);
        int idx_in = 1;
        int idx_out = 1;
        int c = 1;
        int first_c = 0;
        int last_c = 0;
        bit acc;
        i_cf = 2'd1;
        i_en = 1'b1;
        i_data = 32'(idx_in);
        i_valid = 1'b1;
        while (idx_out <= n && c < 200) begin
            o_ready = !(c >= stall_at && c < stall_at + stall_len);
            #1;
            if (c == stall_at) chk("bp_ready_low", i_ready, 1'b0);
            if (chk_tp && idx_in <= n) chk("tp_ready", i_ready, 1'b1);
            if (!o_ready && c > stall_at) chk("bp_hold", o_data, 64'(idx_out));
            if (o_valid && o_ready) begin
                chk("stream_data", o_data, 64'(idx_out));
                if (first_c == 0) first_c = c;
                last_c = c;
                idx_out++;
            end
            acc = i_valid && i_ready;
            tick();
            c++;
            if (acc) begin
                idx_in++;
                if (idx_in > n) i_valid = 1'b0;
                else i_data = 32'(idx_in);
            end
        end
        i_valid = 1'b0;
        chk("stream_done", 64'(idx_out), 64'(n + 1));
        if (chk_tp) begin
            chk("tp_latency", 64'(first_c), 64'd3);
            chk("tp_last", 64'(last_c), 64'(n + 2));
        end
        o_ready = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, checked before any clock edge.
        #1;
        chk("rst_valid", o_valid, 1'b0);
        chk("rst_data", o_data, 32'h0);
        chk("rst_ovf", o_ovf, 2'b00);
        chk("rst_cnt", o_sample_cnt, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        #1 chk("rst_ready", i_ready, 1'b1);

        // Basic correction.
        send(2'd2, 1'b1, 32'hFFFF_0003);
        send(2'd2, 1'b1, 32'h1234_0000);
        chk("basic_a_valid", o_valid, 1'b1);
        chk("basic_a_data", o_data, 32'hFFFF_0006);
        chk("basic_a_ovf", o_ovf, 2'b00);
        tick();
        chk("basic_b_data", o_data, 32'h2468_0000);
        chk("basic_b_ovf", o_ovf, 2'b00);

        // Overflow on ch0.
        send(2'd2, 1'b1, 32'h0000_9000);
        tick();
        chk("ovf_data", o_data, EXP_OVF_DATA);
        chk("ovf_flag", o_ovf, 2'b01);

        // Bypass, then per-sample enable, then cf=0 with an all-ones code.
        send(2'd3, 1'b0, 32'h0000_0005);
        send(2'd3, 1'b1, 32'h0000_0005);
        chk("bypass_data", o_data, 32'h0000_0005);
        chk("bypass_ovf", o_ovf, 2'b00);
        send(2'd0, 1'b1, 32'h1234_FFFF);
        chk("en_data", o_data, 32'h0000_000F);
        tick();
        chk("cf0_data", o_data, 32'h0000_FFFF);
        chk("cf0_ovf", o_ovf, 2'b00);
        tick();
        chk("idle_valid", o_valid, 1'b0);
        chk("cnt_6", o_sample_cnt, 32'd6);
        chk("wcnt_6", w_cnt, 4'd6);

        // Backpressure with ordered drain.
        stream(5, 3, 4, 1'b0);
        chk("cnt_11", o_sample_cnt, 32'd11);
        chk("wcnt_11", w_cnt, 4'd11);

        // Asynchronous reset with a full pipeline.
        o_ready = 1'b0;
        send(2'd1, 1'b1, 32'h0000_00AA);
        send(2'd1, 1'b1, 32'h0000_00BB);
        chk("full_ready", i_ready, 1'b0);
        chk("full_data", o_data, 32'h0000_00AA);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", o_valid, 1'b0);
        chk("arst_data", o_data, 32'h0);
        chk("arst_ovf", o_ovf, 2'b00);
        chk("arst_cnt", o_sample_cnt, 32'd0);
        chk("arst_w_valid", w_valid, 1'b0);
        chk("arst_w_data", {w_data, w_ovf}, 34'h0);
        tick();
        #2 rst_n = 1'b1;
        #1;
        chk("arst_ready", i_ready, 1'b1);
        chk("arst_w_ready", w_ready, 1'b1);
        o_ready = 1'b1;
        tick();

        // Full-rate streaming and counter wrap at CNT_W=4.
        stream(17, 0, 0, 1'b1);
        chk("cnt_17", o_sample_cnt, 32'd17);
        chk("wcnt_wrap", w_cnt, 4'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
